mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port unified `memory` (combinational read, write on `posedge clk`) between the instruction-fetch unit and the load/store unit of the multicycle core. Each requester uses a req/ack handshake. The arbiter latches one request, drives the memory for exactly one cycle, registers the read data and returns a one-cycle ack. It sits between the core's fetch/LSU stages and the `memory` instance and is the only driver of the memory's address, data and write inputs.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: req/ack arbiter that shares one single-port memory between instruction fetch and the LSU.
// Defining MEM_ARB_ROUND_ROBIN_EN replaces fixed data priority (with starvation counter) by round-robin.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = data port owns the current access
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        data_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;  // 1 = data port wins the next contested arbitration
  always_comb begin
    data_wins = d_req;
    if (i_req && d_req) data_wins = rr_q;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
  always_comb begin
    data_wins = d_req;
    if (i_req && d_req) data_wins = (starve_q < LIMIT);
  end
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`else
    starve_d  = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ACCESS;
          owner_d = data_wins;
          we_d    = data_wins & d_we;
          addr_d  = data_wins ? d_addr : i_addr;
          if (data_wins) wdata_d = d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (i_req && d_req) rr_d = ~data_wins;
`else
          // Saturate so a long data burst cannot wrap the counter back below the limit.
          if (!data_wins) starve_d = 4'd0;
          else if (i_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        i_ack_d = ~owner_q;
        d_ack_d = owner_q;
        if (!we_q) begin
          if (owner_q) d_rdata_d = mem_rdata;
          else         i_rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q      <= 1'b1;
`else
      starve_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  // Write strobe is decoded from state so an asynchronous reset kills it at once.
  assign mem_write = (state_q == ACCESS) && we_q && owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-addressed memory model plus a grant/data reference model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_write;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Little-endian byte memory seen by the DUT; preloaded through a side port.
  logic [7:0]  mem [0:255];
  logic        init_we;
  logic [7:0]  init_a;
  logic [31:0] init_v;
  logic [7:0]  ma;
  assign ma = mem_addr[7:0];
  assign mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

  always @(posedge clk) begin
    if (init_we) begin
      for (int k = 0; k < 4; k++) mem[8'(init_a + k)] <= init_v[8*k +: 8];
    end else if (mem_write) begin
      for (int k = 0; k < 4; k++) mem[8'(ma + k)] <= mem_wdata[8*k +: 8];
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [0:255];
  int          m_cnt;
  bit          m_ptr_data;
  logic [31:0] exp_i_rdata, exp_d_rdata;
  int          checks_total = 0;
  int          checks_passed = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[8'(b + 8'd3)], ref_mem[8'(b + 8'd2)], ref_mem[8'(b + 8'd1)], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) ref_mem[8'(a[7:0] + k)] = v[8*k +: 8];
  endtask

  // Returns 1 when the data port is granted for the given request pattern.
  function automatic bit arb_model(input bit ir, input bit dr);
    bit w;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ir && dr) begin
      w = m_ptr_data;
      m_ptr_data = !w;
    end else w = dr;
`else
    if (ir && dr) w = (m_cnt < LIMIT);
    else          w = dr;
    if (!w)                    m_cnt = 0;
    else if (ir && m_cnt < 15) m_cnt = m_cnt + 1;
`endif
    return w;
  endfunction

  task automatic preload_word(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    init_we = 1'b1; init_a = a; init_v = v;
    @(negedge clk);
    init_we = 1'b0;
    ref_write({24'd0, a}, v);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_cnt = 0; m_ptr_data = 1'b1;
    exp_i_rdata = '0; exp_d_rdata = '0;
  endtask

  // Issues one request and waits (bounded) for its ack; lat = 0 means no ack arrived.
  task automatic run_single(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat,
                            output logic [31:0] rdata, output int wr);
    @(negedge clk);
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else      begin i_req = 1'b1; i_addr = addr; end
    lat = 0; wr = 0; rdata = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_write) wr++;
      if (is_d ? d_ack : i_ack) begin
        lat = n;
        rdata = is_d ? d_rdata : i_rdata;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] ctl;
    @(negedge clk);
    checks_total++;
    if ({i_ack, d_ack, mem_write} !== 3'b000)
      $display("FAIL reset_ctl got %b want 000", {i_ack, d_ack, mem_write});
    else checks_passed++;
    checks_total++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'd0)
      $display("FAIL reset_data got %h %h %h %h want all 0", i_rdata, d_rdata, mem_addr, mem_wdata);
    else checks_passed++;
    reset_n = 1'b1;
    m_cnt = 0; m_ptr_data = 1'b1; exp_i_rdata = '0; exp_d_rdata = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ctl = {mem_write, i_ack, d_ack};
      checks_total++;
      if (ctl !== 3'b000) $display("FAIL idle_cycle%0d got %b want 000", c, ctl);
      else checks_passed++;
    end
  endtask

  task automatic test_fetch();
    bit w;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'd4;
    w = arb_model(1'b1, 1'b0);
    @(negedge clk);
    checks_total++;
    if ({i_ack, mem_write, mem_addr} !== {1'b0, 1'b0, 32'd4})
      $display("FAIL fetch_access got ack=%b we=%b addr=%h want 0 0 4", i_ack, mem_write, mem_addr);
    else checks_passed++;
    @(negedge clk);
    exp_i_rdata = ref_read(32'd4);
    checks_total++;
    if ({i_ack, d_ack, mem_write} !== {!w, w, 1'b0})
      $display("FAIL fetch_ack got i=%b d=%b we=%b want 1 0 0", i_ack, d_ack, mem_write);
    else checks_passed++;
    checks_total++;
    if (i_rdata !== exp_i_rdata) $display("FAIL fetch_rdata got %h want %h", i_rdata, exp_i_rdata);
    else checks_passed++;
    i_req = 1'b0;
    @(negedge clk);
    checks_total++;
    if ({i_ack, mem_write} !== 2'b00) $display("FAIL fetch_ack_width got %b want 00", {i_ack, mem_write});
    else checks_passed++;
  endtask

  task automatic test_write_read();
    int lat, wr;
    logic [31:0] rd;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd8; d_wdata = 32'hF0C0D0E0;
    @(negedge clk);
    checks_total++;
    if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'd8, 32'hF0C0D0E0})
      $display("FAIL write_access got we=%b addr=%h wd=%h want 1 8 f0c0d0e0", mem_write, mem_addr, mem_wdata);
    else checks_passed++;
    @(negedge clk);
    ref_write(32'd8, 32'hF0C0D0E0);
    checks_total++;
    if ({d_ack, i_ack, mem_write} !== 3'b100)
      $display("FAIL write_ack got d=%b i=%b we=%b want 1 0 0", d_ack, i_ack, mem_write);
    else checks_passed++;
    checks_total++;
    if (d_rdata !== exp_d_rdata) $display("FAIL write_keeps_rdata got %h want %h", d_rdata, exp_d_rdata);
    else checks_passed++;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    run_single(1'b1, 1'b0, 32'd8, 32'd0, lat, rd, wr);
    exp_d_rdata = ref_read(32'd8);
    checks_total++;
    if (lat !== 2 || rd !== exp_d_rdata || wr !== 0)
      $display("FAIL read8 got lat=%0d data=%h wr=%0d want 2 %h 0", lat, rd, wr, exp_d_rdata);
    else checks_passed++;
    run_single(1'b1, 1'b0, 32'd6, 32'd0, lat, rd, wr);
    exp_d_rdata = ref_read(32'd6);
    checks_total++;
    if (lat !== 2 || rd !== exp_d_rdata || wr !== 0)
      $display("FAIL read6_unaligned got lat=%0d data=%h wr=%0d want 2 %h 0", lat, rd, wr, exp_d_rdata);
    else checks_passed++;
  endtask

  task automatic test_contention();
    bit w;
    int n, wr;
    logic [31:0] exp;
    apply_reset();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'd4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd16;
    for (int g = 0; g < 10; g++) begin
      w = arb_model(1'b1, 1'b1);
      n = 0; wr = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (mem_write) wr++;
        if (i_ack || d_ack) begin n = c; break; end
      end
      checks_total++;
      if (n == 0) begin
        $display("FAIL contend_timeout grant%0d got no ack want ack", g);
        break;
      end
      if ({d_ack, i_ack} !== {w, !w} || n !== ((g == 0) ? 2 : 3) || wr !== 0)
        $display("FAIL contend_grant%0d got d=%b i=%b gap=%0d wr=%0d want d=%b gap=%0d wr=0",
                 g, d_ack, i_ack, n, wr, w, (g == 0) ? 2 : 3);
      else checks_passed++;
      exp = w ? ref_read(32'd16) : ref_read(32'd4);
      checks_total++;
      if ((w ? d_rdata : i_rdata) !== exp)
        $display("FAIL contend_data%0d got %h want %h", g, w ? d_rdata : i_rdata, exp);
      else checks_passed++;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int lat, wr;
    logic [31:0] rd, word;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd12; d_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #2;
    checks_total++;
    if (mem_write !== 1'b1) $display("FAIL rst_pre_write got %b want 1", mem_write);
    else checks_passed++;
    reset_n = 1'b0;
    #1;
    checks_total++;
    if (mem_write !== 1'b0) $display("FAIL rst_drops_write got %b want 0", mem_write);
    else checks_passed++;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    word = {mem[15], mem[14], mem[13], mem[12]};
    checks_total++;
    if (word !== ref_read(32'd12)) $display("FAIL rst_mem12 got %h want %h", word, ref_read(32'd12));
    else checks_passed++;
    checks_total++;
    if ({i_ack, d_ack, mem_write, i_rdata, d_rdata, mem_addr, mem_wdata} !== 131'd0)
      $display("FAIL rst_outputs got %b%b%b %h %h %h %h want all 0",
               i_ack, d_ack, mem_write, i_rdata, d_rdata, mem_addr, mem_wdata);
    else checks_passed++;
    reset_n = 1'b1;
    m_cnt = 0; m_ptr_data = 1'b1; exp_i_rdata = '0; exp_d_rdata = '0;
    run_single(1'b1, 1'b0, 32'd12, 32'd0, lat, rd, wr);
    exp_d_rdata = ref_read(32'd12);
    checks_total++;
    if (lat !== 2 || rd !== exp_d_rdata)
      $display("FAIL rst_then_read got lat=%0d data=%h want 2 %h", lat, rd, exp_d_rdata);
    else checks_passed++;
  endtask

  task automatic test_random();
    bit pi, pd, w, served_we;
    int n, wr;
    logic [31:0] served_addr, served_wd, got, exp;
    apply_reset();
    pi = 1'b0; pd = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (!pi && ($urandom_range(0, 3) != 0)) begin
        pi = 1'b1; i_req = 1'b1; i_addr = 32'($urandom_range(0, 255));
      end
      if (!pd && ($urandom_range(0, 3) != 0)) begin
        pd = 1'b1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom();
      end
      if (!pi && !pd) begin
        pd = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'($urandom_range(0, 255));
      end
      w = arb_model(pi, pd);
      served_we = w & d_we;
      served_addr = w ? d_addr : i_addr;
      served_wd = d_wdata;
      n = 0; wr = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (mem_write) wr++;
        if (i_ack || d_ack) begin n = c; break; end
      end
      checks_total++;
      if (n == 0) begin
        $display("FAIL rand_timeout txn%0d got no ack want ack", t);
        break;
      end
      if ({d_ack, i_ack} !== {w, !w} || wr !== int'(served_we))
        $display("FAIL rand_grant txn%0d got d=%b i=%b wr=%0d want d=%b wr=%0d",
                 t, d_ack, i_ack, wr, w, served_we);
      else checks_passed++;
      if (w) begin
        if (served_we) ref_write(served_addr, served_wd);
        else           exp_d_rdata = ref_read(served_addr);
        got = d_rdata; exp = exp_d_rdata;
        pd = 1'b0; d_req = 1'b0; d_we = 1'b0;
      end else begin
        exp_i_rdata = ref_read(served_addr);
        got = i_rdata; exp = exp_i_rdata;
        pi = 1'b0; i_req = 1'b0;
      end
      checks_total++;
      if (got !== exp) $display("FAIL rand_data txn%0d got %h want %h", t, got, exp);
      else checks_passed++;
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    init_we = 1'b0; init_a = '0; init_v = '0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    for (int w = 0; w < 64; w++) preload_word(8'(w * 4), $urandom());
    preload_word(8'd4, 32'h04030201);
    preload_word(8'd12, 32'h11223344);
    test_reset();
    test_fetch();
    test_write_read();
    test_contention();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
